// File: rtl/word_fetch_if.sv
// Character stream between word_fetch and its downstream consumer.
interface word_fetch_if;
  logic [7:0] ch_data;
  logic       ch_valid;
  logic       ch_ready;

  modport master (output ch_data, output ch_valid, input ch_ready);
  modport slave  (input ch_data, input ch_valid, output ch_ready);
endinterface

// File: rtl/word_fetch.sv
// Picks a word slot from a random index (avoiding immediate repeats), reads it
// from the ROM one character at a time and streams the characters out.
module word_fetch #(
  parameter int unsigned CHARS   = 8,
  parameter int unsigned ROM_LAT = 1,
  localparam int unsigned CW     = $clog2(CHARS),
  localparam int unsigned AW     = 5 + CW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         rand_idx,
  output logic [AW-1:0]      rom_addr,
  input  logic [7:0]         rom_data,
  word_fetch_if.master       ch,
  output logic               busy,
  output logic               done,
  output logic [4:0]         word_idx,
  output logic [3:0]         word_len
);

  localparam int unsigned LW = 2;
  localparam int unsigned RW = 2;

  typedef enum logic [2:0] {
    IDLE, PICK, READ, WAIT, PUSH, FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] char_cnt_q, char_cnt_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [4:0]    prev_idx_q, prev_idx_d;
  logic          have_prev_q, have_prev_d;
  logic [4:0]    word_idx_q, word_idx_d;
  logic [3:0]    word_len_q, word_len_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]    ch_data_q, ch_data_d;
  logic          ch_valid_q, ch_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // State and output registers; synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      char_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      retry_q     <= '0;
      prev_idx_q  <= '0;
      have_prev_q <= 1'b0;
      word_idx_q  <= '0;
      word_len_q  <= '0;
      rom_addr_q  <= '0;
      ch_data_q   <= '0;
      ch_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      char_cnt_q  <= char_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      retry_q     <= retry_d;
      prev_idx_q  <= prev_idx_d;
      have_prev_q <= have_prev_d;
      word_idx_q  <= word_idx_d;
      word_len_q  <= word_len_d;
      rom_addr_q  <= rom_addr_d;
      ch_data_q   <= ch_data_d;
      ch_valid_q  <= ch_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_d     = state_q;
    char_cnt_d  = char_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    retry_d     = retry_q;
    prev_idx_d  = prev_idx_q;
    have_prev_d = have_prev_q;
    word_idx_d  = word_idx_q;
    word_len_d  = word_len_q;
    rom_addr_d  = rom_addr_q;
    ch_data_d   = ch_data_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = PICK;
      end
      PICK: begin
        // Resample a repeat of the previous word, up to three times.
        if (have_prev_q && (rand_idx == prev_idx_q) && (retry_q < RW'(3))) begin
          retry_d = retry_q + RW'(1);
        end else begin
          word_idx_d = rand_idx;
          char_cnt_d = '0;
          word_len_d = '0;
          retry_d    = '0;
          state_d    = READ;
        end
      end
      READ: begin
        rom_addr_d = {word_idx_q, char_cnt_q};
        lat_cnt_d  = LW'(ROM_LAT);
        state_d    = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q <= LW'(1)) begin
          lat_cnt_d = '0;
          if (rom_data == 8'h00) begin
            state_d = FINISH;
          end else begin
            ch_data_d = rom_data;
            state_d   = PUSH;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LW'(1);
        end
      end
      PUSH: begin
        if (ch_valid_q && ch.ch_ready) begin
          word_len_d = word_len_q + 4'd1;
          if (char_cnt_q == CW'(CHARS - 1)) begin
            state_d = FINISH;
          end else begin
            char_cnt_d = char_cnt_q + CW'(1);
            state_d    = READ;
          end
        end
      end
      FINISH: begin
        prev_idx_d  = word_idx_q;
        have_prev_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ch_valid_d = (state_d == PUSH);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FINISH);
  end

  assign rom_addr    = rom_addr_q;
  assign ch.ch_data  = ch_data_q;
  assign ch.ch_valid = ch_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign word_idx    = word_idx_q;
  assign word_len    = word_len_q;

endmodule

// File: tb/tb_word_fetch.sv
// Directed bench for word_fetch: ROM_LAT=1 instance for the main flow and a
// ROM_LAT=3 instance for the longer latency and ignored-start case.
module tb_word_fetch;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic       start, start3;
  logic [4:0] rand_idx, rand_idx3;
  logic [7:0] rom_addr, rom_addr3;
  logic [7:0] rom_data, rom_data3;
  logic       busy, done, busy3, done3;
  logic [4:0] word_idx, word_idx3;
  logic [3:0] word_len, word_len3;

  logic [7:0] rom [0:255];
  logic [7:0] got_ch   [16];
  logic [7:0] got_addr [16];

  int errors = 0;
  int checks = 0;

  word_fetch_if sif ();
  word_fetch_if sif3 ();

  assign rom_data  = rom[rom_addr];
  assign rom_data3 = rom[rom_addr3];

  word_fetch #(.CHARS(8), .ROM_LAT(1)) dut (
    .clock(clock), .reset(reset), .start(start), .rand_idx(rand_idx),
    .rom_addr(rom_addr), .rom_data(rom_data), .ch(sif.master),
    .busy(busy), .done(done), .word_idx(word_idx), .word_len(word_len)
  );

  word_fetch #(.CHARS(8), .ROM_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .rand_idx(rand_idx3),
    .rom_addr(rom_addr3), .rom_data(rom_data3), .ch(sif3.master),
    .busy(busy3), .done(done3), .word_idx(word_idx3), .word_len(word_len3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input int idx, input string s);
    for (int i = 0; i < s.len(); i++) rom[8'(idx * 8 + i)] = s[i];
  endtask

  // Pulse start on dut and count samples until ch_valid (or done if want_done).
  task automatic start_and_wait(input logic [4:0] idx, input logic want_done, output int n,
                                output logic saw_valid);
    rand_idx = idx;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 1;
    saw_valid = sif.ch_valid;
    while (!(want_done ? done : sif.ch_valid) && n < 30) begin
      tick;
      n++;
      if (sif.ch_valid) saw_valid = 1'b1;
    end
  endtask

  // Drain one word from dut, optionally stalling ch_ready on one character.
  task automatic run_word(input int stall_at, input int stall_n, input string exp, input int idx);
    int n;
    int left;
    int last;
    logic got_done;
    logic [7:0] hold_d, hold_a;
    n = 0;
    left = stall_n;
    got_done = 1'b0;
    hold_d = '0;
    hold_a = '0;
    for (int i = 0; i < 16; i++) begin
      got_ch[i] = '0;
      got_addr[i] = '0;
    end
    for (int c = 0; c < 200 && !got_done; c++) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (n == stall_at && left > 0 && (sif.ch_valid || left < stall_n)) begin
          if (left == stall_n) begin
            hold_d = sif.ch_data;
            hold_a = rom_addr;
          end else begin
            check("stall_valid", 32'(sif.ch_valid), 32'd1);
            check("stall_data", 32'(sif.ch_data), 32'(hold_d));
            check("stall_addr", 32'(rom_addr), 32'(hold_a));
          end
          sif.ch_ready = 1'b0;
          left--;
        end else begin
          sif.ch_ready = 1'b1;
          if (sif.ch_valid) begin
            if (n < 16) begin
              got_ch[n] = sif.ch_data;
              got_addr[n] = rom_addr;
            end
            n++;
          end
        end
        tick;
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
    check("char_count", 32'(n), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      check("char", 32'(got_ch[i]), 32'(exp[i]));
      check("char_addr", 32'(got_addr[i]), 32'(idx * 8 + i));
    end
    check("word_len", 32'(word_len), 32'(exp.len()));
    check("word_idx", 32'(word_idx), 32'(idx));
    last = (exp.len() == 8) ? idx * 8 + 7 : idx * 8 + exp.len();
    check("last_addr", 32'(rom_addr), 32'(last));
    // start in the done cycle must be dropped
    start = 1'b1;
    tick;
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd0);
    check("start_at_done", 32'(busy), 32'd0);
    tick;
    check("start_not_queued", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, nv;
    logic sv;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    load_word(5, "ABCDEFGH");
    load_word(3, "CAT");
    load_word(7, "DOG");
    load_word(12, "SUN");
    start = 1'b0;
    start3 = 1'b0;
    rand_idx = '0;
    rand_idx3 = '0;
    sif.ch_ready = 1'b1;
    sif3.ch_ready = 1'b1;

    reset = 1'b0;
    tick;
    tick;
    check("rst_valid", 32'(sif.ch_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(sif.ch_data), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_idx", 32'(word_idx), 32'd0);
    check("rst_len", 32'(word_len), 32'd0);
    reset = 1'b1;

    // Full word, first start after reset, latency 4
    start_and_wait(5'd5, 1'b0, n, sv);
    check("lat_full", 32'(n), 32'd4);
    run_word(-1, 0, "ABCDEFGH", 5);

    // Short word with backpressure on the second character
    start_and_wait(5'd3, 1'b0, n, sv);
    check("lat_cat", 32'(n), 32'd4);
    run_word(1, 5, "CAT", 3);

    start_and_wait(5'd7, 1'b0, n, sv);
    run_word(-1, 0, "DOG", 7);

    // Repeat of 7 twice, then 12 accepted
    rand_idx = 5'd7;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 1;
    while (!sif.ch_valid && n < 30) begin
      if (n == 3) rand_idx = 5'd12;
      tick;
      n++;
    end
    check("lat_retry2", 32'(n), 32'd6);
    check("retry2_idx", 32'(word_idx), 32'd12);
    run_word(-1, 0, "SUN", 12);

    // Index stuck at previous word: accepted after three retries
    start_and_wait(5'd12, 1'b0, n, sv);
    check("lat_retry3", 32'(n), 32'd7);
    run_word(-1, 0, "SUN", 12);

    // Empty word
    start_and_wait(5'd0, 1'b1, n, sv);
    check("lat_empty", 32'(n), 32'd4);
    check("empty_no_valid", 32'(sv), 32'd0);
    check("empty_len", 32'(word_len), 32'd0);
    check("empty_idx", 32'(word_idx), 32'd0);
    tick;
    check("empty_done_pulse", 32'(done), 32'd0);

    // Reset while a character is waiting for ch_ready
    sif.ch_ready = 1'b0;
    start_and_wait(5'd5, 1'b0, n, sv);
    check("pre_rst_valid", 32'(sif.ch_valid), 32'd1);
    reset = 1'b0;
    tick;
    check("mid_rst_valid", 32'(sif.ch_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_len", 32'(word_len), 32'd0);
    check("mid_rst_data", 32'(sif.ch_data), 32'd0);
    check("mid_rst_addr", 32'(rom_addr), 32'd0);
    reset = 1'b1;
    sif.ch_ready = 1'b1;
    // prev word was 0 before reset; no retry now
    start_and_wait(5'd0, 1'b1, n, sv);
    check("post_rst_lat", 32'(n), 32'd4);
    tick;

    // ROM_LAT=3: latency 6, start during busy ignored
    rand_idx3 = 5'd3;
    start3 = 1'b1;
    tick;
    start3 = 1'b0;
    n = 1;
    while (!sif3.ch_valid && n < 30) begin
      tick;
      n++;
    end
    check("lat3", 32'(n), 32'd6);
    nv = sif3.ch_valid ? 1 : 0;
    rand_idx3 = 5'd5;
    for (int c = 0; c < 100 && !done3; c++) begin
      start3 = (c == 2);
      tick;
      if (sif3.ch_valid) nv++;
    end
    start3 = 1'b0;
    check("lat3_done", 32'(done3), 32'd1);
    check("lat3_chars", 32'(nv), 32'd3);
    check("lat3_len", 32'(word_len3), 32'd3);
    check("lat3_idx", 32'(word_idx3), 32'd3);
    tick;
    tick;
    check("lat3_idle", 32'(busy3), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
